display_source_select: RTL
==========================

# display_source_select

Upstream feeder for the two-byte seven-segment display: debounces a push-button that cycles through four view modes, captures datapath write data, keeps a saturating write counter, and drives the registered NumberA/NumberB bytes the display block consumes. Sits between the Lab 7 datapath and the display driver; all outputs are registered so the display sees glitch-free values.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range 2..2^24-1
- NUM_WIDTH, 8, byte width of each display number; fixed at 8, not to be overridden

Ports:
- Clk  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high reset
- BtnNext  in  1  raw, asynchronous push-button; press advances view mode
- WrEn  in  1  datapath register-write strobe, sampled each rising edge
- WrData  in  32  datapath write data, captured when WrEn=1
- PC  in  32  current program counter, sampled live
- NumberA  out  8  lower display byte (right two digits)
- NumberB  out  8  upper display byte (left two digits)
- Mode  out  2  current view mode, for LEDs
- StepPulse  out  1  one-cycle pulse on each accepted press

## Operation
- Synchronizer: BtnNext through two flops (s1, s2); s2 is the debouncer input.
- Debouncer: Stable register (reset 0), counter (reset 0). If s2 == Stable, counter clears. Otherwise counter increments; the cycle the counter reaches DEBOUNCE_CYCLES-1 while s2 still differs, Stable <= s2 and counter clears. Any bounce back to Stable before then clears the counter.
- StepPulse = registered (Stable rising 0->1); high exactly one cycle per accepted press; release produces no pulse.
- Mode: 2-bit register, reset 0; increments on StepPulse, wraps 3 -> 0.
- Capture: Captured[31:0] <= WrData when WrEn; reset 0.
- WrCount[15:0]: increments on WrEn, saturates at 16'hFFFF; reset 0.
- Output mux (registered):
  - Mode 0 (PC_DATA): B = PC[7:0], A = Captured[7:0]
  - Mode 1 (DATA_LO): B = Captured[15:8], A = Captured[7:0]
  - Mode 2 (DATA_HI): B = Captured[31:24], A = Captured[23:16]
  - Mode 3 (COUNT): B = WrCount[15:8], A = WrCount[7:0]
- Reset values: NumberA = 0, NumberB = 0, Mode = 0, StepPulse = 0; all internal registers 0.

## Timing
- Button: raw edge -> s2 in 2 cycles -> Stable after DEBOUNCE_CYCLES further stable cycles -> StepPulse 1 cycle later -> Mode updates at the edge ending the StepPulse cycle -> NumberA/B reflect the new mode 1 cycle after that.
- WrEn sampled at edge k: Captured/WrCount update at edge k; NumberA/B reflect them at edge k+1.
- PC to NumberB (mode 0): 1 cycle.
- WrEn and StepPulse in the same cycle: both take effect; next output uses new Mode and new Captured.
- WrEn while WrCount = FFFF: Captured updates, WrCount holds.
- Reset asserted mid-debounce or mid-pulse: all state clears immediately, and StepPulse drops asynchronously. A button held through reset release is re-debounced from Stable=0 and yields one StepPulse after DEBOUNCE_CYCLES+3 cycles.

## Structure
- Shared package: mode encodings (MODE_PC_DATA=0, MODE_DATA_LO=1, MODE_DATA_HI=2, MODE_COUNT=3), WRCOUNT_MAX=16'hFFFF.
- Counter width = $clog2(DEBOUNCE_CYCLES).
- Sub-module: button_debounce (synchronizer, debounce counter, Stable, StepPulse), reusable for other lab buttons. Capture, counter and output mux live in the top.

## Test plan
Simulation runs with DEBOUNCE_CYCLES=4.
- Reset, then idle 10 cycles -> NumberA=00, NumberB=00, Mode=0, StepPulse never high.
- PC=32'h0000_0034; WrEn one cycle with WrData=32'hDEAD_BEEF -> next cycle A=EF, B=34. Three clean presses -> Mode 1: B=BE, A=EF; Mode 2: B=DE, A=AD; Mode 3: B=00, A=01. Each press gives exactly one StepPulse, and a fourth press wraps to Mode 0.
- Bounce: BtnNext toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one StepPulse, DEBOUNCE_CYCLES+3 cycles after the final edge. Release with bounce -> no pulse.
- Saturation: Mode 3 with 65537 WrEn cycles -> B=FF, A=FF and stays there; Captured still tracks the last WrData.
- Simultaneous events: WrEn with WrData=32'h1234_5678 in the same cycle as StepPulse (Mode 0->1) -> next output B=56, A=78.
- Reset mid-operation: Reset asserted during a debounce count and again during StepPulse -> outputs go to 0 immediately. Button held across reset release -> one StepPulse 7 cycles after release, Mode=1.

Source files
------------

// File: rtl/display_source_select_pkg.sv
// -----------------------------------------------------------------------------
// display_source_select_pkg
// Shared constants for the display source selector: the view-mode encodings
// shown on the LEDs, and the saturation ceiling of the write counter.
// -----------------------------------------------------------------------------
package display_source_select_pkg;

   localparam logic [1:0]  MODE_PC_DATA = 2'd0;  // B = PC[7:0],        A = data[7:0]
   localparam logic [1:0]  MODE_DATA_LO = 2'd1;  // B = data[15:8],     A = data[7:0]
   localparam logic [1:0]  MODE_DATA_HI = 2'd2;  // B = data[31:24],    A = data[23:16]
   localparam logic [1:0]  MODE_COUNT   = 2'd3;  // B = count[15:8],    A = count[7:0]

   localparam logic [15:0] WRCOUNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchronizer plus counter debouncer for a raw push-button, with a
// registered one-cycle pulse on every accepted press (rising level only).
// Ports:
//   Clk    in   system clock
//   Reset  in   asynchronous active-high reset
//   Btn    in   raw asynchronous button level
//   Pulse  out  one-cycle pulse, one clock after the debounced level rises
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Btn,
   output logic Pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          stable_q, stable_d;
   logic          prev_q;
   logic          pulse_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized level disagrees with the
   // accepted level; any agreement (a bounce back) restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_LAST) stable_d = s2_q;
         else                   cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         prev_q   <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         s1_q     <= Btn;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         // Edge detect on the registered level so the pulse is itself a
         // flop output, one cycle after Stable rises.
         prev_q   <= stable_q;
         pulse_q  <= stable_q & ~prev_q;
      end
   end

   assign Pulse = pulse_q;

endmodule

// File: rtl/display_source_select.sv
// -----------------------------------------------------------------------------
// display_source_select
// Feeds the two-byte seven-segment display: a debounced button steps through
// four view modes, datapath writes are captured and counted (saturating), and
// the selected bytes are registered onto NumberA/NumberB.
// Ports:
//   Clk        in   system clock
//   Reset      in   asynchronous active-high reset
//   BtnNext    in   raw button, each press advances the view mode
//   WrEn       in   datapath register-write strobe
//   WrData     in   datapath write data, captured when WrEn=1
//   PC         in   current program counter (live)
//   NumberA    out  lower display byte
//   NumberB    out  upper display byte
//   Mode       out  current view mode
//   StepPulse  out  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module display_source_select
   import display_source_select_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned NUM_WIDTH       = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 BtnNext,
   input  logic                 WrEn,
   input  logic [31:0]          WrData,
   input  logic [31:0]          PC,
   output logic [NUM_WIDTH-1:0] NumberA,
   output logic [NUM_WIDTH-1:0] NumberB,
   output logic [1:0]           Mode,
   output logic                 StepPulse
);

   logic                 step;
   logic [1:0]           mode_q;
   logic [31:0]          cap_q;
   logic [15:0]          wrcnt_q;
   logic [NUM_WIDTH-1:0] num_a_q, num_a_d;
   logic [NUM_WIDTH-1:0] num_b_q, num_b_d;
   logic                 unused_pc_hi;

   assign unused_pc_hi = ^PC[31:8];

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .Clk   (Clk),
      .Reset (Reset),
      .Btn   (BtnNext),
      .Pulse (step)
   );

   always_comb begin
      num_a_d = cap_q[7:0];
      num_b_d = PC[7:0];
      case (mode_q)
         MODE_PC_DATA: begin num_b_d = PC[7:0];        num_a_d = cap_q[7:0];   end
         MODE_DATA_LO: begin num_b_d = cap_q[15:8];    num_a_d = cap_q[7:0];   end
         MODE_DATA_HI: begin num_b_d = cap_q[31:24];   num_a_d = cap_q[23:16]; end
         MODE_COUNT:   begin num_b_d = wrcnt_q[15:8];  num_a_d = wrcnt_q[7:0]; end
         default:      ;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mode_q  <= MODE_PC_DATA;
         cap_q   <= '0;
         wrcnt_q <= '0;
         num_a_q <= '0;
         num_b_q <= '0;
      end else begin
         // 2-bit add wraps 3 -> 0 on its own.
         if (step) mode_q <= mode_q + 2'd1;
         if (WrEn) begin
            cap_q <= WrData;
            if (wrcnt_q != WRCOUNT_MAX) wrcnt_q <= wrcnt_q + 16'd1;
         end
         num_a_q <= num_a_d;
         num_b_q <= num_b_d;
      end
   end

   assign NumberA   = num_a_q;
   assign NumberB   = num_b_q;
   assign Mode      = mode_q;
   assign StepPulse = step;

endmodule
